// File: rtl/hazard_controller.sv
// Hazard controller: EX/MEM/WB destination tracking, operand forwarding selects,
// load-use stall and a one-cycle wrong-path kill after a taken transfer in ID.
module hazard_controller #(
   parameter int REG_BITS = 3,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                id_valid,
   input  logic [REG_BITS-1:0] RA,
   input  logic [REG_BITS-1:0] RB,
   input  logic                id_usesA,
   input  logic                id_usesB,
   input  logic [REG_BITS-1:0] TargetDestinationRegister,
   input  logic                id_regwrite,
   input  logic                id_isload,
   input  logic                branch_taken,
   input  logic                jump,
   output logic [1:0]          ForwardA,
   output logic [1:0]          ForwardB,
   output logic                stall,
   output logic                kill,
   output logic [CNT_BITS-1:0] stall_count,
   output logic [CNT_BITS-1:0] kill_count
);

   typedef struct packed {
      logic                vld;
      logic [REG_BITS-1:0] rd;
      logic                regwrite;
      logic                isload;
   } slot_t;

   typedef enum logic {RUN, FLUSH} state_t;

   slot_t  ex_slot, mem_slot, wb_slot;
   slot_t  id_slot;
   state_t state, next_state;
   logic   load_hazard;
   logic   accept;

   // R0 is hardwired zero, so it never matches a producer.
   function automatic logic hit(input slot_t s, input logic [REG_BITS-1:0] src);
      return s.vld & s.regwrite & (s.rd == src) & (src != '0);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_BITS-1:0] src,
                                          input slot_t ex, input slot_t mem, input slot_t wb);
      logic [1:0] sel;
      sel = 2'd0;
      if (used) begin
         if (hit(ex, src))
            sel = 2'd1;
         else if (hit(mem, src))
            sel = 2'd2;
         else if (hit(wb, src))
            sel = 2'd3;
      end
      return sel;
   endfunction

   always_comb begin
      ForwardA    = fwd_sel(id_usesA, RA, ex_slot, mem_slot, wb_slot);
      ForwardB    = fwd_sel(id_usesB, RB, ex_slot, mem_slot, wb_slot);
      kill        = (state == FLUSH);
      load_hazard = ex_slot.isload &
                    ((id_usesA & hit(ex_slot, RA)) | (id_usesB & hit(ex_slot, RB)));
      stall       = id_valid & ~kill & load_hazard;
      accept      = id_valid & ~stall & ~kill;
      id_slot          = '0;
      id_slot.vld      = accept;
      id_slot.rd       = TargetDestinationRegister;
      id_slot.regwrite = id_regwrite;
      id_slot.isload   = id_isload;
   end

   // A stalled transfer is not taken yet; it is re-evaluated once the stall clears.
   always_comb begin
      next_state = state;
      case (state)
         RUN:     if (accept & (branch_taken | jump)) next_state = FLUSH;
         FLUSH:   next_state = RUN;
         default: next_state = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_slot     <= '0;
         mem_slot    <= '0;
         wb_slot     <= '0;
         state       <= RUN;
         stall_count <= '0;
         kill_count  <= '0;
      end else begin
         ex_slot  <= id_slot;
         mem_slot <= ex_slot;
         wb_slot  <= mem_slot;
         state    <= next_state;
         if (stall && (stall_count != '1))
            stall_count <= stall_count + CNT_BITS'(1);
         if (kill && (kill_count != '1))
            kill_count <= kill_count + CNT_BITS'(1);
      end
   end

endmodule
